// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : RISC-V instruction decode with the ID/EX pipeline register.
//               Decodes the IF/ID instruction, selects operands (with a
//               same-cycle write-back bypass), builds the immediate, detects
//               load-use hazards and inserts bubbles on stall or flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        ex_flush,
    output logic [4:0]  read_reg1,
    output logic [4:0]  read_reg2,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic [6:0]  ex_opcode,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_alu_src,
    output logic        ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Raw instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = if_instr[6:0];
    assign rd_f   = if_instr[11:7];
    assign rs1_f  = if_instr[19:15];
    assign rs2_f  = if_instr[24:20];

    // Register file addresses come straight from the instruction fields
    assign read_reg1 = rs1_f;
    assign read_reg2 = rs2_f;

    // Decoded bundle
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        alu_src;
    logic        illegal;
    logic [31:0] imm;

    // Opcode decode: field usage, controls and immediate format
    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        rd_used   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        alu_src   = 1'b0;
        illegal   = 1'b0;
        imm       = 32'd0;
        case (opcode)
            OP_R: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
            end
            OP_IALU, OP_LOAD: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                alu_src  = 1'b1;
                is_load  = (opcode == OP_LOAD);
                imm      = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                alu_src  = 1'b1;
                is_store = 1'b1;
                imm      = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                is_branch = 1'b1;
                imm       = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                             if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                rd_used = 1'b1;
                alu_src = 1'b1;
                is_jump = 1'b1;
                imm     = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                alu_src  = 1'b1;
                is_jump  = 1'b1;
                imm      = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                rd_used = 1'b1;
                alu_src = 1'b1;
                imm     = {if_instr[31:12], 12'd0};
            end
            default: begin
                // Unknown opcode: flagged, no register or memory side effects
                illegal = 1'b1;
            end
        endcase
    end

    // Effective indices: unused fields collapse to x0
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign rs1_idx = rs1_used ? rs1_f : 5'd0;
    assign rs2_idx = rs2_used ? rs2_f : 5'd0;
    assign rd_idx  = rd_used  ? rd_f  : 5'd0;

    // Operand select: x0 is hard zero, then same-cycle write-back bypass,
    // then the register file; an unused field has index 0 and so reads 0
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    // Operand multiplexing for both source registers
    always_comb begin
        if (rs1_idx == 5'd0)
            rs1_val = 32'd0;
        else if (wb_reg_write && (wb_write_reg == rs1_idx))
            rs1_val = wb_write_data;
        else
            rs1_val = read_data1;

        if (rs2_idx == 5'd0)
            rs2_val = 32'd0;
        else if (wb_reg_write && (wb_write_reg == rs2_idx))
            rs2_val = wb_write_data;
        else
            rs2_val = read_data2;
    end

    // Load-use hazard against the load currently sitting in ID/EX
    logic haz;

    assign haz = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                 ((rs1_used && (ex_rd == rs1_f)) || (rs2_used && (ex_rd == rs2_f)));

    // A flush discards the stalled instruction anyway, so it releases the stall
    assign id_stall = haz && !ex_flush && !reset;

    // ID/EX register: reset, then flush/hazard bubble, then load, else bubble
    always_ff @(posedge clk) begin
        if (reset || ex_flush || haz || !if_valid) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_rs1_data  <= 32'd0;
            ex_rs2_data  <= 32'd0;
            ex_imm       <= 32'd0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_funct3    <= 3'd0;
            ex_funct7b5  <= 1'b0;
            ex_opcode    <= 7'd0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rs1_data  <= rs1_val;
            ex_rs2_data  <= rs2_val;
            ex_imm       <= imm;
            ex_rs1       <= rs1_idx;
            ex_rs2       <= rs2_idx;
            ex_rd        <= rd_idx;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_opcode    <= opcode;
            ex_reg_write <= rd_used && (rd_f != 5'd0);
            ex_mem_read  <= is_load;
            ex_mem_write <= is_store;
            ex_branch    <= is_branch;
            ex_jump      <= is_jump;
            ex_alu_src   <= alu_src;
            ex_illegal   <= illegal;
        end
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Instruction-decode stage with its ID/EX pipeline register for the RISC-V core. It takes the instruction held in IF/ID and decodes it. It drives the register file read addresses, bypasses the write-back value that the register file has not yet committed, and generates the immediate. The decoded bundle is registered for EX. It also detects load-use hazards, stalls the front end, and inserts bubbles on stall or on an EX-stage flush.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction in IF/ID.
- if_pc  in  32  PC of if_instr.
- ex_flush  in  1  branch/jump resolved taken in EX; squash the instruction now in ID.
- read_reg1, read_reg2  out  5  register file read addresses: if_instr[19:15] and [24:20], combinational.
- read_data1, read_data2  in  32  register file read data, combinational.
- wb_reg_write  in  1  write-back writes this cycle.
- wb_write_reg  in  5  write-back destination register.
- wb_write_data  in  32  write-back data.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32  registered PC, operands, and sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices; 0 when the field is unused.
- ex_funct3  out  3;  ex_funct7b5  out  1 (instr[30]);  ex_opcode  out  7.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_illegal  out  1  registered controls.

## Operation
- **Decode by opcode:**
  - R 0110011: rs1, rs2, rd used.
  - I-ALU 0010011 and LOAD 0000011: rs1, rd used; I-immediate.
  - STORE 0100011: rs1, rs2 used; S-immediate.
  - BRANCH 1100011: rs1, rs2 used; B-immediate.
  - JAL 1101111: rd used; J-immediate.
  - JALR 1100111: rs1, rd used; I-immediate.
  - LUI 0110111 and AUIPC 0010111: rd used; U-immediate.
- **Immediates:** all are sign-extended from instr[31]. B and J immediates have bit 0 = 0. The U immediate is instr[31:12]<<12.
- **Controls:**
  - reg_write = rd used and rd≠0.
  - mem_read = LOAD.
  - mem_write = STORE.
  - branch = BRANCH.
  - jump = JAL|JALR.
  - alu_src = 1 for all opcodes except R and BRANCH.
- **Illegal opcode:** any other opcode sets ex_illegal=1 with ex_valid=1 and all write/memory controls 0.
- **Operand select, rs1 (rs2 identical):**
  - rs1=0 → 0.
  - Otherwise, if wb_reg_write && wb_write_reg==rs1 → wb_write_data.
  - Otherwise → read_data1.
  - x0 is never taken from the register file.
- **Unused fields:** a field the opcode does not use loads its index as 0 and its data as 0.
- **Load-use hazard:** haz = if_valid && ex_valid && ex_mem_read && ex_rd≠0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)).
- **ID/EX register update each posedge, in priority order:**
  1. reset → all ex_* outputs 0.
  2. ex_flush → bubble.
  3. haz → bubble.
  4. if_valid → load the decoded bundle.
  5. else → bubble.
- **Bubble:** ex_valid=0 and every control 0. Data fields are don't-care; they are loaded as 0.
- **id_stall** = haz && !ex_flush && !reset.

## Timing
- Reset value of every registered output is 0; id_stall is 0 while reset is high.
- Latency: the instruction in ID at edge N appears on ex_* after edge N+1.
- Stall lasts exactly one cycle per load-use pair. The next cycle the load has left ID/EX, so haz deasserts and the held instruction loads.
- Bypass is same-cycle. A write-back at edge N is visible to the instruction decoded in that cycle, with no stall.
- **Simultaneous events:**
  - Flush and haz together: flush wins and no stall.
  - Flush and if_valid together: the IF/ID instruction is dropped.
  - Reset mid-stall: bubble, stall released.

## Test plan
- **Reset:** hold reset 2 cycles with if_valid=1 and instr 0x00500093 → all ex_* 0 and id_stall 0. After release, the next edge gives ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_src=1.
- **Bypass:** decode add x3,x1,x2 (0x002081B3) while wb writes x1=0xDEADBEEF and read_data1=0x1 → ex_rs1_data=0xDEADBEEF. The same case with wb_write_reg=0 → 0x1.
- **x0:** decode add x0,x0,x0 with read_data=0xFFFFFFFF and wb writing x0 → ex_rs1_data=0, ex_rs2_data=0, ex_reg_write=0.
- **Load-use:** lw x5,0(x1) followed by add x6,x5,x5:
  - One id_stall cycle.
  - ex_valid=0 for one cycle.
  - The add then appears with ex_rs1=ex_rs2=5.
  - lw x0 followed by a use of x0 → no stall.
- **Flush:** ex_flush=1 during a load-use stall → id_stall=0 and a bubble is loaded. A beq immediate of -8 (0xFE000CE3) gives ex_imm=0xFFFFFFF8.
- **Illegal:** opcode 1111111 → ex_illegal=1, ex_valid=1, ex_reg_write=ex_mem_write=0.
